// File: rtl/ql_rom_loader_if.sv
// Download/ROM-write bundle between the HPS download port and the ROM loader.
// The rom_sum signal exists only when ROM_LOADER_SUM_EN is defined.
interface ql_rom_loader_if #(
    parameter int AW = 15
);
    // HPS download side
    logic          ioctl_download;
    logic [7:0]    ioctl_index;
    logic          ioctl_wr;
    logic [24:0]   ioctl_addr;
    logic [15:0]   ioctl_data;
    logic          ioctl_wait;

    // ROM write port and status
    logic          rom_we;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data;
    logic          rom_busy;
    logic          rom_valid;
    logic [AW:0]   rom_words;
    logic          overflow;
`ifdef ROM_LOADER_SUM_EN
    logic [15:0]   rom_sum;
`endif

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_data,
`ifdef ROM_LOADER_SUM_EN
        output rom_sum,
`endif
        output ioctl_wait, rom_we, rom_addr, rom_data, rom_busy, rom_valid,
               rom_words, overflow
    );

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_data,
`ifdef ROM_LOADER_SUM_EN
        input  rom_sum,
`endif
        input  ioctl_wait, rom_we, rom_addr, rom_data, rom_busy, rom_valid,
               rom_words, overflow
    );
endinterface

// File: rtl/ql_rom_loader.sv
// QL system ROM loader: byte-swaps HPS download words into the ROM, then pads the rest with FILL_WORD.
// Optional image checksum output enabled by defining ROM_LOADER_SUM_EN.
module ql_rom_loader #(
    parameter int          AW        = 15,
    parameter logic [15:0] FILL_WORD = 16'hFFFF,
    parameter logic [7:0]  INDEX     = 8'd0
) (
    input  logic            clk,
    input  logic            reset_n,
    ql_rom_loader_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FILL
    } state_t;

    state_t        state_q;
    logic          ioctl_wait_q;
    logic          rom_we_q;
    logic [AW-1:0] rom_addr_q;
    logic [15:0]   rom_data_q;
    logic          rom_busy_q;
    logic          rom_valid_q;
    logic [AW:0]   rom_words_q;
    logic          overflow_q;
    logic [AW:0]   fill_ptr_q;
`ifdef ROM_LOADER_SUM_EN
    logic [15:0]   rom_sum_q;
`endif

    logic          index_hit;
    logic          wr_hit;
    logic          addr_oob;
    logic          wr_accept;
    logic [AW-1:0] wa;
    logic [15:0]   swapped;
    logic [AW:0]   wa_end;
    logic [AW:0]   rom_words_d;
    logic [AW:0]   fill_ptr_d;
    logic          unused_addr_lsb;

    assign index_hit = (bus.ioctl_index == INDEX);
    assign wr_hit    = bus.ioctl_wr && index_hit;
    // Any byte address at or beyond 2^(AW+1) lies outside the ROM.
    assign addr_oob  = ((bus.ioctl_addr >> (AW + 1)) != 25'd0);
    assign wr_accept = (state_q == ST_LOAD) && wr_hit && !addr_oob;
    assign wa        = bus.ioctl_addr[AW:1];
    assign swapped   = {bus.ioctl_data[7:0], bus.ioctl_data[15:8]};
    assign wa_end    = {1'b0, wa} + {{AW{1'b0}}, 1'b1};

    // High-water mark including a write landing this cycle, so a write coincident
    // with the download falling edge still moves the fill start point.
    assign rom_words_d = (wr_accept && (wa_end > rom_words_q)) ? wa_end : rom_words_q;
    assign fill_ptr_d  = fill_ptr_q + {{AW{1'b0}}, 1'b1};

    assign unused_addr_lsb = bus.ioctl_addr[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            ioctl_wait_q <= 1'b0;
            rom_we_q     <= 1'b0;
            rom_addr_q   <= '0;
            rom_data_q   <= '0;
            rom_busy_q   <= 1'b0;
            rom_valid_q  <= 1'b0;
            rom_words_q  <= '0;
            overflow_q   <= 1'b0;
            fill_ptr_q   <= '0;
`ifdef ROM_LOADER_SUM_EN
            rom_sum_q    <= '0;
`endif
        end else begin
            rom_we_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.ioctl_download && index_hit) begin
                        state_q     <= ST_LOAD;
                        rom_busy_q  <= 1'b1;
                        rom_valid_q <= 1'b0;
                        rom_words_q <= '0;
                        overflow_q  <= 1'b0;
`ifdef ROM_LOADER_SUM_EN
                        rom_sum_q   <= '0;
`endif
                    end
                end

                ST_LOAD: begin
                    if (wr_hit) begin
                        if (addr_oob) begin
                            overflow_q <= 1'b1;
                        end else begin
                            rom_we_q   <= 1'b1;
                            rom_addr_q <= wa;
                            rom_data_q <= swapped;
`ifdef ROM_LOADER_SUM_EN
                            rom_sum_q  <= rom_sum_q + swapped;
`endif
                        end
                    end
                    rom_words_q <= rom_words_d;
                    if (!bus.ioctl_download) begin
                        if (!rom_words_d[AW]) begin
                            state_q      <= ST_FILL;
                            fill_ptr_q   <= rom_words_d;
                            ioctl_wait_q <= 1'b1;
                        end else begin
                            state_q     <= ST_IDLE;
                            rom_busy_q  <= 1'b0;
                            rom_valid_q <= 1'b1;
                        end
                    end
                end

                ST_FILL: begin
                    rom_we_q   <= 1'b1;
                    rom_addr_q <= fill_ptr_q[AW-1:0];
                    rom_data_q <= FILL_WORD;
                    fill_ptr_q <= fill_ptr_d;
                    // Carry into the top pointer bit marks the last ROM word.
                    if (fill_ptr_d[AW]) begin
                        state_q      <= ST_IDLE;
                        ioctl_wait_q <= 1'b0;
                        rom_busy_q   <= 1'b0;
                        rom_valid_q  <= 1'b1;
                    end
                end

                default: begin
                    state_q      <= ST_IDLE;
                    ioctl_wait_q <= 1'b0;
                    rom_busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ioctl_wait = ioctl_wait_q;
    assign bus.rom_we     = rom_we_q;
    assign bus.rom_addr   = rom_addr_q;
    assign bus.rom_data   = rom_data_q;
    assign bus.rom_busy   = rom_busy_q;
    assign bus.rom_valid  = rom_valid_q;
    assign bus.rom_words  = rom_words_q;
    assign bus.overflow   = overflow_q;
`ifdef ROM_LOADER_SUM_EN
    assign bus.rom_sum    = rom_sum_q;
`endif

endmodule

// File: doc/ql_rom_loader.md
# ql_rom_loader

Download-side ROM loader for the QL core. It sits between the HPS download interface and the 32K-word system ROM dual-port RAM, which it feeds. It byte-swaps incoming words and writes them into the ROM. After a short image it pads the rest of the ROM with a fill pattern. It reports busy, valid and size status to the reset and LED logic.

## Interface
Parameters:
- `AW`, 15, ROM word-address width; ROM depth is 2^AW words.
- `FILL_WORD`, 16'hFFFF, pattern written to ROM words the image did not cover.
- `INDEX`, 8'd0, `ioctl_index` value selecting ROM downloads.

Ports:
- `clk  in  1` — system clock; every register is clocked on its rising edge.
- `reset_n  in  1` — reset, asynchronous, active-low.
- `ioctl_download  in  1` — download in progress (level).
- `ioctl_index  in  8` — download target index.
- `ioctl_wr  in  1` — one-cycle write strobe.
- `ioctl_addr  in  25` — byte address, always even.
- `ioctl_data  in  16` — data word; the low byte is the first file byte.
- `ioctl_wait  out  1` — stall request to HPS; high during FILL.
- `rom_we  out  1` — ROM write strobe, one cycle per word.
- `rom_addr  out  AW` — ROM word address.
- `rom_data  out  16` — ROM write data, big-endian order.
- `rom_busy  out  1` — high in LOAD or FILL; the reset logic holds the CPU in reset while this is high.
- `rom_valid  out  1` — a complete load plus fill has finished since reset or since the last LOAD entry.
- `rom_words  out  AW+1` — high-water count of words written by the image.
- `overflow  out  1` — sticky; a write beyond the ROM depth was dropped.
- `rom_sum  out  16` — image checksum; present only when `ROM_LOADER_SUM_EN` is defined.

## Operation
States are IDLE, LOAD and FILL.

- **IDLE**
  - If `ioctl_download` is high and `ioctl_index == INDEX` (level test), go to LOAD.
  - On entry to LOAD, clear `rom_words`, `overflow`, `rom_valid` and `rom_sum`.
- **LOAD**, on each `ioctl_wr` that arrives with a matching index:
  - Word address `wa = ioctl_addr[AW:1]`. Bit 0 is ignored.
  - If `ioctl_addr[24:AW+1] != 0`: set `overflow` and do not write.
  - Otherwise write `{ioctl_data[7:0], ioctl_data[15:8]}` to `wa`, and set `rom_words = max(rom_words, wa+1)`.
  - Writes with a non-matching index are ignored.
  - On `ioctl_download` low:
    - if `rom_words < 2^AW`, go to FILL with the fill pointer at `rom_words`;
    - otherwise go to IDLE and set `rom_valid`.
- **FILL**
  - Write `FILL_WORD` at the fill pointer every cycle, then increment the pointer.
  - After writing address 2^AW−1, go to IDLE and set `rom_valid`.
  - `ioctl_wr` pulses arriving in FILL are ignored; upstream must not write while `ioctl_wait` is high.
- **Back-to-back downloads:** if a download with a matching index is already high when FILL ends, IDLE enters LOAD on the next cycle.
- **Arithmetic:** the fill pointer is AW+1 bits wide so that terminal detection does not wrap. `rom_words` saturates at 2^AW.
- **Empty download** (no writes): all 2^AW words are filled.
- **Reset:** asserting `reset_n` low at any time, including mid-LOAD or mid-FILL, immediately forces IDLE. All outputs go to 0, including `ioctl_wait` and `rom_valid`. ROM contents are left as they are.

## Timing
- **Write latency:** `ioctl_wr` at cycle N gives `rom_we`/`rom_addr`/`rom_data` at N+1. Each write is a single cycle, with no backpressure in LOAD.
- **LOAD to FILL:** `ioctl_download` seen low at cycle N gives FILL from N+1, with the first fill write at N+1.
- **FILL duration:** filling k words takes k cycles. IDLE, `rom_busy`=0 and `rom_valid`=1 occur on the cycle after the last fill write.
- **No fill needed:** if no fill is needed, `rom_busy` falls and `rom_valid` rises at N+1.
- **`ioctl_wait`:** equals (state == FILL), registered.
- **`rom_busy`:** registered; high from the cycle after the LOAD entry condition.
- **Simultaneous events:** an `ioctl_wr` in the same cycle as `ioctl_download` falling is still written.

## Configuration
- **`ROM_LOADER_SUM_EN` defined:**
  - `rom_sum` accumulates the 16-bit wraparound sum of the byte-swapped image words actually written in LOAD. Fill words and dropped words are excluded.
  - The sum is cleared on LOAD entry and is stable once `rom_valid` is high.
- **`ROM_LOADER_SUM_EN` undefined:**
  - The `rom_sum` port and the adder are absent.
  - All other behaviour is identical.

## Test plan
- **Short image.** Index 0; writes at byte addresses 0, 2, 4, 6 with data 16'h3412, 16'h7856, 16'hBC9A, 16'hF0DE; then drop download.
  - Expect: `rom_we` at addresses 0–3 with data 16'h1234/5678/9ABC/DEF0, each one cycle after its strobe; `rom_words`=4.
  - Expect: 32764 fill writes of 16'hFFFF at 4..32767, with `ioctl_wait` high throughout.
  - Expect: `rom_valid`=1 and `rom_busy`=0 on the next cycle.
- **Full 64 KiB image.** Expect no FILL cycles, `ioctl_wait` never high, and `rom_busy` falling one cycle after download falls.
- **Overflow.** Write at byte address 25'h10000 → `overflow`=1, no `rom_we`, `rom_words` unchanged.
- **Wrong index.** Download with index 1 and 10 writes → no `rom_we`; `rom_busy`=0 throughout.
- **Reset mid-operation.** Assert `reset_n` low at fill pointer 100 → `ioctl_wait`, `rom_busy`, `rom_we` and `rom_valid` all 0 in the same cycle. A new download after release reloads cleanly.
- **Checksum (`ROM_LOADER_SUM_EN` defined).**
  - Stimulus: image words (pre-swap) 16'h0100, 16'h0200, 16'hFFFF.
  - Expect: `rom_sum`=16'h0002 (1+2+FFFF wraps), unaffected by fill.
